gbuff_rd_streamer: RTL and testbench

Read-side master for one global buffer instance. Accepts a burst command (base index, word count) and issues sequential reads on the buffer's wr_en/index port. It absorbs the buffer's 1-cycle registered read latency and delivers the words as a valid/ready stream with a last flag. The block sits between the global buffer and compute consumers (PE array feeders, DMA-out path).

---
 rtl/gbuff_pkg.sv | 15 +
 rtl/gbuff_sync_fifo.sv | 66 ++++++
 rtl/gbuff_rd_streamer.sv | 156 +++++++++++++++
 tb/tb_gbuff_rd_streamer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_pkg.sv
// Shared definitions for global-buffer users: default geometry and the
// read-streamer state encoding.
package gbuff_pkg;

    localparam int GB_ADDR_BITS = 8;
    localparam int GB_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gb_state_e;

endpackage

// File: rtl/gbuff_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is presented
// combinationally from the storage registers.
module gbuff_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gbuff_rd_streamer.sv
// Burst read master for one global buffer: issues sequential indices, absorbs the
// buffer's one-cycle read latency and emits the words as a valid/ready stream.
module gbuff_rd_streamer
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS  = GB_ADDR_BITS,
    parameter int DATA_BITS  = GB_DATA_BITS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [ADDR_BITS-1:0] cmd_base_i,
    input  logic [ADDR_BITS:0]   cmd_len_i,
    output logic                 gb_wr_en_o,
    output logic [ADDR_BITS-1:0] gb_index_o,
    input  logic [DATA_BITS-1:0] gb_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = ADDR_BITS + 1;

    gb_state_e            state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     issued_q, issued_d;
    logic [LEN_W-1:0]     pushed_q, pushed_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0] idx_hold_q;
    logic                 rd_pend_q;

    logic                 issue;
    logic                 pop;
    logic                 can_issue;
    logic                 drain_clear;
    logic                 push_last;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS:0]   fifo_rdata;
    logic [CNT_W:0]       occ;
    logic [CNT_W:0]       limit;

    assign pop = out_valid_o & out_ready_i;

    // Credit: words in the FIFO plus the read in flight, less the word leaving now,
    // must leave room for one more so the pending read can never overflow.
    assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
    assign limit     = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
    assign can_issue = (~fifo_full | pop) & (occ < limit);

    // Finish once the FIFO will be empty after this cycle and nothing is in flight.
    assign drain_clear = ~rd_pend_q &
                         (fifo_empty | ((fifo_count == CNT_W'(1)) & pop));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_addr_d = rd_addr_q;
        issued_d  = issued_q;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    len_d     = cmd_len_i;
                    rd_addr_d = cmd_base_i;
                    issued_d  = '0;
                    state_d   = (cmd_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = can_issue;
                if (can_issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    issued_d  = issued_q + 1'b1;
                    if (issued_q + LEN_W'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_clear) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pushed_d = pushed_q;
        if (state_q == IDLE) begin
            pushed_d = '0;
        end else if (rd_pend_q) begin
            pushed_d = pushed_q + 1'b1;
        end
    end

    assign push_last = (pushed_q == len_q - LEN_W'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            rd_addr_q  <= '0;
            idx_hold_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            pushed_q   <= pushed_d;
            rd_addr_q  <= rd_addr_d;
            idx_hold_q <= gb_index_o;
            rd_pend_q  <= issue;
        end
    end

    gbuff_sync_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rd_pend_q),
        .wdata_i ({push_last, gb_data_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign gb_wr_en_o  = 1'b0;
    assign gb_index_o  = issue ? rd_addr_q : idx_hold_q;
    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = fifo_rdata[DATA_BITS-1:0];
    assign out_last_o  = fifo_rdata[DATA_BITS] & ~fifo_empty;

endmodule

// File: tb/tb_gbuff_rd_streamer.sv
// Scenario bench for gbuff_rd_streamer with a registered-read buffer model and an
// in-order expected-word queue per burst.
module tb_gbuff_rd_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_base = '0;
    logic [8:0] cmd_len = '0;
    logic       gb_wr_en;
    logic [7:0] gb_index;
    logic [7:0] gb_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Global buffer: registered read of the presented index.
    always @(posedge clk) gb_data <= mem[gb_index];

    gbuff_rd_streamer #(.ADDR_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
        .gb_wr_en_o(gb_wr_en), .gb_index_o(gb_index), .gb_data_i(gb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns at 1 time unit into cycle 1 (the cycle after the handshake edge).
    task automatic send_cmd(input logic [7:0] b, input logic [8:0] l);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base = b; cmd_len = l;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, gb_wr_en, busy, done, out_valid, out_last} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 100000",
                {cmd_ready, gb_wr_en, busy, done, out_valid, out_last});
        end
        n_tests++;
        if ({gb_index, out_data} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got idx %h data %h want 00 00", gb_index, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        out_ready = 1'b1;
        send_cmd(8'd4, 9'd3);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (c <= 3) begin
                n_tests++;
                if (gb_index !== 8'(3 + c)) begin
                    n_fail++; $display("FAIL basic_index c%0d: got %0d want %0d", c, gb_index, 3 + c);
                end
            end
            n_tests++;
            if (out_valid !== (c >= 3 && c <= 5) || done !== (c == 6) || busy !== (c <= 6)) begin
                n_fail++; $display("FAIL basic_ctrl c%0d: got v%b d%b b%b", c, out_valid, done, busy);
            end
            if (c >= 3 && c <= 5) begin
                n_tests++;
                if (out_data !== 8'(c + 1) || out_last !== (c == 5)) begin
                    n_fail++; $display("FAIL basic_data c%0d: got %0d last %b want %0d last %b",
                        c, out_data, out_last, c + 1, (c == 5));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int dones = 0;
        out_ready = 1'b1;
        send_cmd(8'd255, 9'd3);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (done) dones++;
            if (c <= 3) begin
                n_tests++;
                if (gb_index !== 8'(254 + c)) begin
                    n_fail++; $display("FAIL wrap_index c%0d: got %0d want %0d", c, gb_index, 8'(254 + c));
                end
            end
            if (c >= 3 && c <= 5) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== 8'(252 + c) || out_last !== (c == 5)) begin
                    n_fail++; $display("FAIL wrap_data c%0d: got v%b %0d last %b want %0d",
                        c, out_valid, out_data, out_last, 8'(252 + c));
                end
            end
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++; $display("FAIL wrap_done: got %0d pulses want 1", dones);
        end
    endtask

    task automatic test_stall();
        int got = 0; int dones = 0; int c = 1;
        logic stall = 1'b0; logic [7:0] prev = '0;
        send_cmd(8'd20, 9'd5);
        while (dones == 0 && c < 60) begin
            if (c > 1) begin @(posedge clk); #1; end
            out_ready = !(c >= 2 && c <= 8);
            @(negedge clk);
            if (stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== prev) begin
                    n_fail++; $display("FAIL stall_hold c%0d: got v%b %0d want v1 %0d", c, out_valid, out_data, prev);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (gb_index !== 8'd21 || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_credit: got idx %0d v%b want idx 21 v1", gb_index, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (got >= 5 || out_data !== 8'(20 + got) || out_last !== (got == 4)) begin
                    n_fail++; $display("FAIL stall_word %0d: got %0d last %b want %0d last %b",
                        got, out_data, out_last, 20 + got, (got == 4));
                end
                got++;
            end
            if (done) dones++;
            stall = out_valid && !out_ready;
            prev  = out_data;
            c++;
        end
        n_tests++;
        if (got != 5 || dones != 1) begin
            n_fail++; $display("FAIL stall_total: got %0d words %0d done want 5 1", got, dones);
        end
    endtask

    task automatic test_len0();
        int dones = 0; logic [7:0] idx0; logic seen_valid = 1'b0; logic idx_moved = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        idx0 = gb_index;
        send_cmd(8'd7, 9'd0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (done) dones++;
            if (out_valid) seen_valid = 1'b1;
            if (gb_index !== idx0) idx_moved = 1'b1;
        end
        n_tests++;
        if (dones != 1 || seen_valid || idx_moved) begin
            n_fail++; $display("FAIL len0: got %0d done valid %b idxmove %b want 1 0 0", dones, seen_valid, idx_moved);
        end
    endtask

    task automatic test_reset_midburst();
        int got = 0; int dones = 0; int c = 1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        out_ready = 1'b1;
        send_cmd(8'd10, 9'd20);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, busy, done, out_valid, out_last} !== 5'b10000 || gb_index !== 8'd0 || out_data !== 8'd0) begin
            n_fail++; $display("FAIL midreset: got rdy%b b%b d%b v%b l%b idx %0d data %0d want 1 0 0 0 0 0 0",
                cmd_ready, busy, done, out_valid, out_last, gb_index, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(8'd0, 9'd2);
        while (dones == 0 && c < 30) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_tests++;
                if (got >= 2 || out_data !== 8'(got) || out_last !== (got == 1)) begin
                    n_fail++; $display("FAIL postreset_word %0d: got %0d last %b want %0d", got, out_data, out_last, got);
                end
                got++;
            end
            if (done) dones++;
            c++;
        end
        n_tests++;
        if (got != 2 || dones != 1) begin
            n_fail++; $display("FAIL postreset_total: got %0d words %0d done want 2 1", got, dones);
        end
    endtask

    task automatic test_random();
        logic [7:0] b; logic [8:0] l; logic [7:0] exp_q[$];
        logic stall; logic [7:0] prev;
        int got; int lasts; int dones; int c;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int bst = 0; bst < 4; bst++) begin
            b = 8'($urandom);
            l = (bst == 0) ? 9'd256 : 9'($urandom_range(1, 9));
            exp_q.delete();
            for (int k = 0; k < int'(l); k++) exp_q.push_back(mem[8'(int'(b) + k)]);
            send_cmd(b, l);
            got = 0; lasts = 0; dones = 0; c = 1; stall = 1'b0; prev = '0;
            while (dones == 0 && c < 3000) begin
                if (c > 1) begin @(posedge clk); #1; end
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (stall) begin
                    n_tests++;
                    if (out_valid !== 1'b1 || out_data !== prev) begin
                        n_fail++; $display("FAIL rand_hold b%0d: got v%b %0d want %0d", bst, out_valid, out_data, prev);
                    end
                end
                if (out_valid && out_ready) begin
                    n_tests++;
                    if (got >= int'(l) || out_data !== exp_q[got] || out_last !== (got == int'(l) - 1)) begin
                        n_fail++; $display("FAIL rand_word b%0d #%0d: got %0d last %b want %0d",
                            bst, got, out_data, out_last, (got < int'(l)) ? exp_q[got] : 8'hxx);
                    end
                    if (out_last) lasts++;
                    got++;
                end
                if (done) dones++;
                stall = out_valid && !out_ready;
                prev  = out_data;
                c++;
            end
            n_tests++;
            if (got != int'(l) || lasts != 1 || dones != 1) begin
                n_fail++; $display("FAIL rand_total b%0d: got %0d words %0d last %0d done want %0d 1 1",
                    bst, got, lasts, dones, l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
